// File: rtl/sigdel_adc_decim.sv
// Sigma-delta bitstream to offset-binary PCM: 3rd-order CIC decimator with a one-entry output register.
// Build option: define SIGDEL_ADC_SYNC_EN to add a 2-flop synchronizer on bit_in (adds 2 clk latency).
//
// state     | meaning
// ST_WARM0  | no decimated result seen yet since reset, next one is dropped
// ST_WARM1  | one result dropped, next one is dropped too
// ST_RUN    | comb history valid, every result is presented
module sigdel_adc_decim #(
    parameter int BITLEN = 16,
    parameter int DECIM  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_in,
    output logic [BITLEN-1:0] out_sample,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ovf
);

    localparam int LOG2D = $clog2(DECIM);
    localparam int W     = 2 + 3 * LOG2D;
    localparam int SHIFT = 3 * LOG2D - (BITLEN - 1);

    localparam logic [LOG2D-1:0]    CNT_LAST = LOG2D'(DECIM - 1);
    localparam logic signed [W-1:0] S_MAX    = W'((2 ** (BITLEN - 1)) - 1);
    localparam logic signed [W-1:0] S_MIN    = ~S_MAX;

    if (DECIM < 2 || DECIM != (1 << LOG2D) || SHIFT < 0) begin : g_bad_param
        $error("sigdel_adc_decim: DECIM must be a power of two with 3*log2(DECIM) >= BITLEN-1");
    end

    typedef enum logic [1:0] {
        ST_WARM0 = 2'd0,
        ST_WARM1 = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  bit_s;
    logic signed [W-1:0]   x_in;
    logic signed [W-1:0]   integ1_q, integ1_d, integ2_q, integ2_d, integ3_q, integ3_d;
    logic [LOG2D-1:0]      cnt_q, cnt_d;
    logic signed [W-1:0]   dec_q, dec_d;
    logic                  dec_vld_q, dec_vld_d;
    logic signed [W-1:0]   z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
    logic signed [W-1:0]   c1, c2, c3;
    logic signed [W-1:0]   acc_q, acc_d;
    logic                  acc_vld_q, acc_vld_d;
    logic signed [W-1:0]   s_full, sat;
    logic [BITLEN-1:0]     pcm;
    logic [BITLEN-1:0]     out_sample_q, out_sample_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_ovf_q, out_ovf_d;

`ifdef SIGDEL_ADC_SYNC_EN
    logic [1:0] sync_q, sync_d;
    assign sync_d = {sync_q[0], bit_in};
    assign bit_s  = sync_q[1];
`else
    assign bit_s = bit_in;
`endif

    always_comb begin
        // integrators are chained combinationally so the block's last bit lands in dec_q on its own edge
        x_in     = bit_s ? W'(1) : '1;
        integ1_d = integ1_q + x_in;
        integ2_d = integ2_q + integ1_d;
        integ3_d = integ3_q + integ2_d;

        cnt_d     = cnt_q + LOG2D'(1);
        dec_vld_d = (cnt_q == CNT_LAST);
        dec_d     = dec_vld_d ? integ3_d : dec_q;

        c1 = dec_q - z1_q;
        c2 = c1 - z2_q;
        c3 = c2 - z3_q;
        z1_d      = dec_vld_q ? dec_q : z1_q;
        z2_d      = dec_vld_q ? c1 : z2_q;
        z3_d      = dec_vld_q ? c2 : z3_q;
        acc_d     = dec_vld_q ? c3 : acc_q;
        acc_vld_d = dec_vld_q && (state_q == ST_RUN);

        state_d = state_q;
        if (dec_vld_q) begin
            case (state_q)
                ST_WARM0: state_d = ST_WARM1;
                ST_WARM1: state_d = ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end

        s_full = acc_q >>> SHIFT;
        if (s_full > S_MAX) begin
            sat = S_MAX;
        end else if (s_full < S_MIN) begin
            sat = S_MIN;
        end else begin
            sat = s_full;
        end
        pcm = BITLEN'(sat);
        pcm[BITLEN-1] = ~pcm[BITLEN-1];

        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        out_ovf_d    = out_ovf_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (acc_vld_q) begin
            out_sample_d = pcm;
            out_valid_d  = 1'b1;
            if (out_valid_q && !out_ready) begin
                out_ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_WARM0;
            integ1_q     <= '0;
            integ2_q     <= '0;
            integ3_q     <= '0;
            cnt_q        <= '0;
            dec_q        <= '0;
            dec_vld_q    <= 1'b0;
            z1_q         <= '0;
            z2_q         <= '0;
            z3_q         <= '0;
            acc_q        <= '0;
            acc_vld_q    <= 1'b0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            out_ovf_q    <= 1'b0;
`ifdef SIGDEL_ADC_SYNC_EN
            sync_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            integ1_q     <= integ1_d;
            integ2_q     <= integ2_d;
            integ3_q     <= integ3_d;
            cnt_q        <= cnt_d;
            dec_q        <= dec_d;
            dec_vld_q    <= dec_vld_d;
            z1_q         <= z1_d;
            z2_q         <= z2_d;
            z3_q         <= z3_d;
            acc_q        <= acc_d;
            acc_vld_q    <= acc_vld_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            out_ovf_q    <= out_ovf_d;
`ifdef SIGDEL_ADC_SYNC_EN
            sync_q       <= sync_d;
`endif
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_sigdel_adc_decim.sv
// Bench for sigdel_adc_decim (DECIM=64, BITLEN=16): a direct-form sinc^3 convolution model feeds a
// scoreboard queue at each block end; samples are popped and compared when the DUT hands them over.
module tb_sigdel_adc_decim;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bit_in = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] out_sample;
    logic        out_valid;
    logic        out_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;
    int blk      = 0;
    int pops     = 0;
    int cur_test = 0;
    bit sb_en    = 1'b1;
    int xh [0:2047];
    int h  [0:189];
    logic [15:0] exp_q [$];
    logic [15:0] dac_acc;

    sigdel_adc_decim #(.BITLEN(16), .DECIM(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sinc^3 taps = three length-64 boxcars convolved
    function automatic void build_taps();
        int b2 [0:126];
        for (int k = 0; k <= 126; k++) b2[k] = ((k < 126 - k) ? k : 126 - k) + 1;
        for (int k = 0; k <= 189; k++) begin
            h[k] = 0;
            for (int j = 0; j < 64; j++) begin
                if (k - j >= 0 && k - j <= 126) h[k] += b2[k - j];
            end
        end
    endfunction

    function automatic logic [15:0] model(input int tt);
        longint acc = 0;
        longint s;
        for (int k = 0; k <= 189; k++) begin
            if (tt - k >= 1) acc += longint'(h[k] * xh[tt - k]);
        end
        s = acc >>> 3;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s + 32768);
    endfunction

    task automatic step(input logic b);
        bit_in = b;
        @(posedge clk);
        #1;
        t++;
        xh[t] = b ? 1 : -1;
        if (t % 64 == 0) begin
            blk++;
            if (blk >= 3 && sb_en) exp_q.push_back(model(t));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        t = 0;
        blk = 0;
        pops = 0;
        dac_acc = '0;
        exp_q.delete();
    endtask

    function automatic logic dac_bit();
        logic [16:0] sum;
        sum = {1'b0, dac_acc} + 17'h04000;
        dac_acc = sum[15:0];
        return sum[16];
    endfunction

    task automatic finish_seg(input string tag, input int exp_pops);
        for (int i = 0; i < 3; i++) step(bit_in);
        check_eq({tag, "_pops"}, 32'(pops), 32'(exp_pops));
        check_eq({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (sb_en && rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected", 32'(out_sample), 32'hFFFF_FFFF);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                pops++;
                check_eq("sb_sample", 32'(out_sample), 32'(e));
                if (cur_test == 4) begin
                    check_eq("dac_tol",
                             32'((out_sample >= 16'h3FFE && out_sample <= 16'h4002) ? 1 : 0), 32'd1);
                end
            end
        end
    end

    initial begin
        build_taps();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_eq("rst_sample", 32'(out_sample), 32'h0);
        check_eq("rst_valid", 32'(out_valid), 32'h0);
        check_eq("rst_ovf", 32'(out_ovf), 32'h0);

        cur_test = 1;
        for (int i = 1; i <= 320; i++) begin
            step(1'b1);
            if (i == 193) check_eq("t1_pre_valid", 32'(out_valid), 32'd0);
            if (i == 194) begin
                check_eq("t1_first_valid", 32'(out_valid), 32'd1);
                check_eq("t1_first_sample", 32'(out_sample), 32'hFFFF);
            end
            if (i == 195) check_eq("t1_consumed", 32'(out_valid), 32'd0);
        end
        finish_seg("t1", 3);

        cur_test = 2;
        do_reset();
        for (int i = 1; i <= 320; i++) begin
            step(1'b0);
            if (i == 258) check_eq("t2_period_valid", 32'(out_valid), 32'd1);
            if (i == 257) check_eq("t2_gap_valid", 32'(out_valid), 32'd0);
        end
        finish_seg("t2", 3);

        cur_test = 3;
        do_reset();
        for (int i = 1; i <= 320; i++) step(i[0]);
        finish_seg("t3", 3);
        check_eq("t3_ovf", 32'(out_ovf), 32'd0);

        cur_test = 4;
        do_reset();
        for (int i = 1; i <= 768; i++) step(dac_bit());
        finish_seg("t4", 10);

        cur_test = 5;
        do_reset();
        sb_en = 1'b0;
        out_ready = 1'b0;
        for (int i = 1; i <= 321; i++) begin
            step(1'b1);
            if (i == 194) begin
                check_eq("t5_valid", 32'(out_valid), 32'd1);
                check_eq("t5_ovf_before", 32'(out_ovf), 32'd0);
            end
            if (i == 230) begin
                check_eq("t5_hold_valid", 32'(out_valid), 32'd1);
                check_eq("t5_hold_sample", 32'(out_sample), 32'hFFFF);
            end
            if (i == 257) check_eq("t5_ovf_pre", 32'(out_ovf), 32'd0);
            if (i == 258) begin
                check_eq("t5_ovf_set", 32'(out_ovf), 32'd1);
                check_eq("t5_ow_valid", 32'(out_valid), 32'd1);
            end
        end
        out_ready = 1'b1;
        step(1'b1);
        check_eq("t5_load_consume_valid", 32'(out_valid), 32'd1);
        check_eq("t5_ovf_sticky", 32'(out_ovf), 32'd1);
        step(1'b1);
        check_eq("t5_drained", 32'(out_valid), 32'd0);
        check_eq("t5_ovf_still", 32'(out_ovf), 32'd1);

        cur_test = 6;
        for (int i = 0; i < 30; i++) step(1'b1);
        do_reset();
        sb_en = 1'b1;
        check_eq("t6_sample", 32'(out_sample), 32'h0);
        check_eq("t6_valid", 32'(out_valid), 32'h0);
        check_eq("t6_ovf", 32'(out_ovf), 32'h0);
        for (int i = 1; i <= 320; i++) begin
            step(1'b0);
            if (i == 130) check_eq("t6_drop2_valid", 32'(out_valid), 32'd0);
            if (i == 194) check_eq("t6_first_valid", 32'(out_valid), 32'd1);
        end
        finish_seg("t6", 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
